memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- Pipeline stage directly upstream of write-back. Takes the execute-stage result (ALU result / effective address, store data, opcode, funct3, destination register).
- For loads and stores, performs one data-memory transaction over a valid/ready request channel and a valid-only response channel.
- Aligns and extends load data. Presents ALU result, loaded data, opcode and destination register to write-back through a registered valid/ready output.
- Non-memory instructions pass through with one cycle of latency.

Parameters:
- XLEN, 32, datapath and address width (only 32 supported)
- RESP_TIMEOUT, 64, max cycles waiting for mem_resp_valid before a bus fault is flagged (≥2)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  execute-stage instruction valid
- in_ready  out  1  stage can accept (high only in IDLE, or in DONE when out_ready)
- in_opcode  in  7  RISC-V opcode
- in_funct3  in  3  load/store size and signedness
- in_alu_result  in  XLEN  ALU result or effective address
- in_store_data  in  XLEN  rs2 value for stores
- in_dest_reg  in  5  rd
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  word-aligned address (low 2 bits zero)
- mem_req_we  out  1  1 = store
- mem_req_wstrb  out  4  byte enables
- mem_req_wdata  out  XLEN  lane-shifted store data
- mem_resp_valid  in  1  response valid (one per request, loads and stores)
- mem_resp_rdata  in  XLEN  read word
- out_valid  out  1  result valid to write-back
- out_ready  in  1  write-back accepts
- out_opcode  out  7  forwarded opcode
- out_alu_result  out  XLEN  forwarded ALU result
- out_loaded_data  out  XLEN  aligned, extended load data (0 for non-loads)
- out_dest_reg  out  5  rd (forced 0 on fault)
- out_fault  out  2  00 none, 01 misaligned, 10 bus timeout

Behaviour:
- **Reset:** Synchronous. All outputs 0, state IDLE, timeout counter 0. Reset mid-transaction abandons the request. A mem_resp_valid arriving after reset is ignored until a new request is issued.
- **States:** IDLE, REQ, WAIT, DONE.
- **IDLE, in_valid high:**
  - Inputs are latched.
  - Non-memory opcode (not 0000011 / 0100011) → DONE. out_valid is high the next cycle (latency 1).
  - Memory op that is misaligned → DONE with out_fault = 01 and no request. Misaligned means halfword with addr[0] set, or word with addr[1:0] ≠ 0.
  - Aligned memory op → REQ.
- **REQ:**
  - mem_req_valid is high; request fields are stable until mem_req_ready is seen.
  - On handshake → WAIT, counter cleared.
  - The counter also runs in REQ; expiry goes to DONE with fault 10.
- **WAIT:**
  - The counter increments each cycle.
  - On mem_resp_valid → DONE, load data latched.
  - When the counter reaches RESP_TIMEOUT-1 without a response → DONE with fault 10.
  - If the response and expiry occur in the same cycle, the response wins.
- **DONE:**
  - out_valid is high; outputs are held until out_ready.
  - out_ready with in_valid → accept the next instruction in the same cycle (back-to-back). Otherwise → IDLE.
- **Minimum load latency:** accept edge N, request in cycle N+1, response earliest N+2, out_valid at N+3.
- **Store lanes** (off = addr[1:0]):
  - SB: wstrb = 1 << off, wdata = byte replicated ×4.
  - SH: wstrb = 0011 << off, wdata = halfword replicated ×2.
  - SW: wstrb = 1111.
- **Load extract:**
  - Select the byte or halfword at off.
  - funct3 000 → LB (sign-extend), 001 → LH (sign-extend), 010 → LW.
  - funct3 100 → LBU (zero-extend), 101 → LHU (zero-extend).
  - Any other funct3 → misaligned-class fault 01.
- **Fault handling:** out_dest_reg is forced 0 and out_loaded_data is 0, so write-back writes nothing useful.

Decomposition:
- Shared pipeline package holds:
  - opcode localparams (OP_LOAD, OP_STORE, …)
  - funct3 size encodings
  - mem_fault_e enum
  - the state enum
- Sub-module **load_store_align**: purely combinational. Provides store wstrb/wdata generation and load extract/extension, so it can be reused by a future cache.

Test Plan:
- ADDI, opcode 0010011, alu_result 0x0000_0005, rd 3 → out_valid one cycle after accept with out_alu_result = 5, out_dest_reg = 3, out_loaded_data = 0, no mem_req_valid.
- LB at addr 0x103, memory returns 0x80_00_00_00 → mem_req_addr 0x100, out_loaded_data 0xFFFF_FF80. LBU at the same address → 0x0000_0080.
- SH at addr 0x202, data 0x0000_BEEF → mem_req_wstrb 1100, mem_req_wdata 0xBEEF_BEEF, mem_req_we 1. Response completes → out_valid.
- LW at addr 0x006 → no request, out_fault 01, out_dest_reg 0, in_ready low until out_ready.
- LW with mem_req_ready held low 3 cycles, then response withheld for RESP_TIMEOUT cycles → fault 10.
- Response on the final counter cycle → normal completion.
- Back-to-back: out_ready held low 4 cycles, outputs stable; then out_ready and in_valid together → new instruction accepted that cycle. Reset asserted while in WAIT → all outputs 0 the next cycle, and a stale response is ignored.

Source files
------------

// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared opcode, funct3, fault and state definitions for the memory-access stage
package memory_access_pkg;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {FAULT_NONE = 2'b00, FAULT_MISALIGN = 2'b01, FAULT_BUS = 2'b10} mem_fault_e;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
  // Unsupported funct3 is reported in the same class as a misaligned access.
  function automatic logic mem_bad(input logic [6:0] op, input logic [2:0] f3, input logic [1:0] off);
    return (op == OP_STORE ? (f3[2] || f3[1:0] == 2'b11) : (f3 == 3'b011 || f3[2:1] == 2'b11))
        || (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
  endfunction
endpackage

// File: rtl/load_store_align.sv
// load_store_align: combinational store lane placement and load byte/halfword extraction with extension
// Ports: off_i byte offset, funct3_i size/sign, store_data_i rs2, load_word_i read word,
//        wstrb_o/wdata_o store lanes, load_data_o aligned and extended load value.
module load_store_align
  import memory_access_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);
  logic [31:0] shifted;
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    wstrb_o = funct3_i[1:0] == 2'b00 ? 4'b0001 << off_i : funct3_i[1:0] == 2'b01 ? 4'b0011 << off_i : 4'b1111;
    wdata_o = funct3_i[1:0] == 2'b00 ? {4{store_data_i[7:0]}} : funct3_i[1:0] == 2'b01 ? {2{store_data_i[15:0]}} : store_data_i;
    shifted = load_word_i >> {off_i, 3'b000};
    b = shifted[7:0];
    h = shifted[15:0];
    load_data_o = funct3_i == F3_B  ? {{24{b[7]}}, b} :
                  funct3_i == F3_H  ? {{16{h[15]}}, h} :
                  funct3_i == F3_BU ? {24'b0, b} :
                  funct3_i == F3_HU ? {16'b0, h} : load_word_i;
  end
endmodule

// File: rtl/memory_access.sv
// memory_access: pipeline stage performing one data-memory transaction per load/store ahead of write-back
// Ports: in_* execute-stage instruction (valid/ready), mem_req_* request channel (valid/ready),
//        mem_resp_* response channel (valid only), out_* registered result to write-back (valid/ready).
module memory_access
  import memory_access_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [4:0]      in_dest_reg,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_we,
  output logic [3:0]      mem_req_wstrb,
  output logic [XLEN-1:0] mem_req_wdata,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [6:0]      out_opcode,
  output logic [XLEN-1:0] out_alu_result,
  output logic [XLEN-1:0] out_loaded_data,
  output logic [4:0]      out_dest_reg,
  output logic [1:0]      out_fault
);
  localparam int CW = $clog2(RESP_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(RESP_TIMEOUT - 1);
  state_e          state_q, state_d;
  mem_fault_e      fault_q, fault_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] alu_q, alu_d, sd_q, sd_d, ldata_q, ldata_d;
  logic [4:0]      rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      wstrb;
  logic [XLEN-1:0] wdata, ld_aligned;
  logic            mem_op, bad;
  load_store_align u_align (
    .off_i(alu_q[1:0]),
    .funct3_i(f3_q),
    .store_data_i(sd_q),
    .load_word_i(mem_resp_rdata),
    .wstrb_o(wstrb),
    .wdata_o(wdata),
    .load_data_o(ld_aligned)
  );
  assign in_ready        = state_q == S_IDLE || (state_q == S_DONE && out_ready);
  assign mem_req_valid   = state_q == S_REQ;
  assign mem_req_we      = mem_req_valid && opcode_q == OP_STORE;
  assign mem_req_addr    = mem_req_valid ? {alu_q[XLEN-1:2], 2'b00} : '0;
  assign mem_req_wstrb   = mem_req_we ? wstrb : '0;
  assign mem_req_wdata   = mem_req_we ? wdata : '0;
  assign out_valid       = state_q == S_DONE;
  assign out_opcode      = opcode_q;
  assign out_alu_result  = alu_q;
  assign out_loaded_data = ldata_q;
  assign out_dest_reg    = fault_q == FAULT_NONE ? rd_q : 5'd0;
  assign out_fault       = fault_q;
  assign mem_op          = in_opcode == OP_LOAD || in_opcode == OP_STORE;
  assign bad             = mem_bad(in_opcode, in_funct3, in_alu_result[1:0]);
  always_comb begin
    state_d  = state_q;
    fault_d  = fault_q;
    opcode_d = opcode_q;
    f3_d     = f3_q;
    alu_d    = alu_q;
    sd_d     = sd_q;
    rd_d     = rd_q;
    ldata_d  = ldata_q;
    cnt_d    = cnt_q;
    if (in_valid && in_ready) begin
      opcode_d = in_opcode;
      f3_d     = in_funct3;
      alu_d    = in_alu_result;
      sd_d     = in_store_data;
      rd_d     = in_dest_reg;
      ldata_d  = '0;
      cnt_d    = '0;
      fault_d  = FAULT_NONE;
      state_d  = S_DONE;
      if (mem_op && bad) fault_d = FAULT_MISALIGN;
      else if (mem_op) state_d = S_REQ;
    end else begin
      case (state_q)
        S_REQ:
          if (mem_req_ready) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = S_DONE;
            fault_d = FAULT_BUS;
          end else cnt_d = cnt_q + 1'b1;
        S_WAIT:
          if (mem_resp_valid) begin
            state_d = S_DONE;
            ldata_d = opcode_q == OP_LOAD ? ld_aligned : '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = S_DONE;
            fault_d = FAULT_BUS;
          end else cnt_d = cnt_q + 1'b1;
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      fault_q  <= FAULT_NONE;
      opcode_q <= '0;
      f3_q     <= '0;
      alu_q    <= '0;
      sd_q     <= '0;
      rd_q     <= '0;
      ldata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      fault_q  <= fault_d;
      opcode_q <= opcode_d;
      f3_q     <= f3_d;
      alu_q    <= alu_d;
      sd_q     <= sd_d;
      rd_q     <= rd_d;
      ldata_q  <= ldata_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_memory_access.sv
// tb_memory_access: directed self-checking bench for memory_access
module tb_memory_access;
  logic        clk = 1'b0, reset;
  logic        in_valid, in_ready;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result, in_store_data;
  logic [4:0]  in_dest_reg;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        out_valid, out_ready;
  logic [6:0]  out_opcode;
  logic [31:0] out_alu_result, out_loaded_data;
  logic [4:0]  out_dest_reg;
  logic [1:0]  out_fault;
  int errors = 0, checks = 0;
  memory_access dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data), .in_dest_reg(in_dest_reg),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_we(mem_req_we), .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_alu_result(out_alu_result), .out_loaded_data(out_loaded_data),
    .out_dest_reg(out_dest_reg), .out_fault(out_fault)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd);
    in_valid = 1'b1;
    in_opcode = op;
    in_funct3 = f3;
    in_alu_result = alu;
    in_store_data = sd;
    in_dest_reg = rd;
    @(negedge clk);
    in_valid = 1'b0;
  endtask
  task automatic handshake();
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
  endtask
  task automatic respond(input logic [31:0] data);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = data;
    @(negedge clk);
    mem_resp_valid = 1'b0;
  endtask
  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_opcode = '0; in_funct3 = '0; in_alu_result = '0; in_store_data = '0; in_dest_reg = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_fault", 32'(out_fault), 32'd0);
    check("rst_ldata", out_loaded_data, 32'd0);
    check("rst_rd", 32'(out_dest_reg), 32'd0);
    issue(7'b0010011, 3'b000, 32'h5, 32'h0, 5'd3);
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_alu", out_alu_result, 32'h5);
    check("addi_rd", 32'(out_dest_reg), 32'd3);
    check("addi_ldata", out_loaded_data, 32'd0);
    check("addi_noreq", 32'(mem_req_valid), 32'd0);
    release_out();
    check("addi_idle", 32'(out_valid), 32'd0);
    issue(7'b0000011, 3'b000, 32'h103, 32'h0, 5'd5);
    check("lb_req", 32'(mem_req_valid), 32'd1);
    check("lb_addr", mem_req_addr, 32'h100);
    check("lb_we", 32'(mem_req_we), 32'd0);
    handshake();
    respond(32'h8000_0000);
    check("lb_valid", 32'(out_valid), 32'd1);
    check("lb_data", out_loaded_data, 32'hFFFF_FF80);
    check("lb_rd", 32'(out_dest_reg), 32'd5);
    release_out();
    issue(7'b0000011, 3'b100, 32'h103, 32'h0, 5'd5);
    handshake();
    respond(32'h8000_0000);
    check("lbu_data", out_loaded_data, 32'h0000_0080);
    release_out();
    issue(7'b0000011, 3'b001, 32'h102, 32'h0, 5'd8);
    handshake();
    respond(32'h8001_0000);
    check("lh_data", out_loaded_data, 32'hFFFF_8001);
    release_out();
    issue(7'b0100011, 3'b001, 32'h202, 32'h0000_BEEF, 5'd0);
    check("sh_wstrb", 32'(mem_req_wstrb), 32'hC);
    check("sh_wdata", mem_req_wdata, 32'hBEEF_BEEF);
    check("sh_we", 32'(mem_req_we), 32'd1);
    check("sh_addr", mem_req_addr, 32'h200);
    handshake();
    respond(32'h0);
    check("sh_valid", 32'(out_valid), 32'd1);
    check("sh_fault", 32'(out_fault), 32'd0);
    release_out();
    issue(7'b0000011, 3'b010, 32'h6, 32'h0, 5'd7);
    check("mis_noreq", 32'(mem_req_valid), 32'd0);
    check("mis_valid", 32'(out_valid), 32'd1);
    check("mis_fault", 32'(out_fault), 32'd1);
    check("mis_rd", 32'(out_dest_reg), 32'd0);
    check("mis_inready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("mis_hold", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    check("mis_inready_or", 32'(in_ready), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    issue(7'b0000011, 3'b010, 32'h40, 32'h0, 5'd9);
    repeat (3) @(negedge clk);
    check("to_req_hold", 32'(mem_req_valid), 32'd1);
    check("to_addr_hold", mem_req_addr, 32'h40);
    handshake();
    repeat (63) @(negedge clk);
    check("to_not_yet", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("to_valid", 32'(out_valid), 32'd1);
    check("to_fault", 32'(out_fault), 32'd2);
    check("to_rd", 32'(out_dest_reg), 32'd0);
    check("to_ldata", out_loaded_data, 32'd0);
    release_out();
    issue(7'b0000011, 3'b010, 32'h44, 32'h0, 5'd10);
    handshake();
    repeat (63) @(negedge clk);
    check("last_waiting", 32'(out_valid), 32'd0);
    respond(32'h1234_5678);
    check("last_valid", 32'(out_valid), 32'd1);
    check("last_fault", 32'(out_fault), 32'd0);
    check("last_data", out_loaded_data, 32'h1234_5678);
    check("last_rd", 32'(out_dest_reg), 32'd10);
    release_out();
    issue(7'b0010011, 3'b000, 32'h11, 32'h0, 5'd4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_hold_valid", 32'(out_valid), 32'd1);
      check("b2b_hold_alu", out_alu_result, 32'h11);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_opcode = 7'b0000011; in_funct3 = 3'b010; in_alu_result = 32'h80; in_dest_reg = 5'd6;
    #1;
    check("b2b_inready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("b2b_req", 32'(mem_req_valid), 32'd1);
    check("b2b_addr", mem_req_addr, 32'h80);
    check("b2b_outvalid", 32'(out_valid), 32'd0);
    handshake();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("wrst_valid", 32'(out_valid), 32'd0);
    check("wrst_req", 32'(mem_req_valid), 32'd0);
    check("wrst_alu", out_alu_result, 32'd0);
    check("wrst_opcode", 32'(out_opcode), 32'd0);
    respond(32'hDEAD_BEEF);
    check("stale_valid", 32'(out_valid), 32'd0);
    check("stale_ldata", out_loaded_data, 32'd0);
    check("stale_inready", 32'(in_ready), 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
